mux_nx1_rr: RTL and testbench

//  Parametrised N-channel, DW-bit registered multiplexer with valid/ready output handshake.
//  Two modes: manual select (sel port) or round-robin scan over requesting channels.

---
 rtl/mux_nx1_rr.sv | 144 ++++++++++++++
 tb/tb_mux_nx1_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// -----------------------------------------------------------------------------
// mux_nx1_rr
//   N-channel, DW-bit registered multiplexer. One output register is fed
//   either from a manually selected channel or from a round-robin scan over
//   the channels that currently request. The output uses a valid/ready
//   handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   mode      0 = manual select via sel, 1 = round-robin scan
//   sel       channel index used in manual mode
//   din       packed channel data, channel k = din[k*DW +: DW]
//   din_vld   per-channel data valid
//   din_ack   one-hot pulse, asserted with the registered sample it belongs to
//   dout      registered selected data
//   dout_ch   channel index that dout came from
//   dout_vld  dout/dout_ch hold a valid sample
//   dout_rdy  sink accepts the sample when dout_vld & dout_rdy
// -----------------------------------------------------------------------------
module mux_nx1_rr #(
  parameter int N_CH = 16,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N_CH*DW-1:0]   din,
  input  logic [N_CH-1:0]      din_vld,
  output logic [N_CH-1:0]      din_ack,
  output logic [DW-1:0]        dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_vld,
  input  logic                 dout_rdy
);

  logic [DW-1:0]   r_dout;
  logic [SELW-1:0] r_dout_ch;
  logic            r_dout_vld;
  logic [N_CH-1:0] r_din_ack;
  logic [SELW-1:0] r_ptr;

  logic [DW-1:0]   w_ch_data [N_CH];
  logic [N_CH-1:0] w_man_hit;
  logic [N_CH-1:0] w_above_ptr;
  logic [N_CH-1:0] w_req_hi;
  logic [N_CH-1:0] w_ack_vec;
  logic            w_man_gnt;
  logic            w_rr_gnt;
  logic [SELW-1:0] w_rr_idx;
  logic            w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic [DW-1:0]   w_gnt_data;
  logic            w_load;

  // The output register may take a new sample when it is empty or being
  // drained this same cycle (no bubble on back-to-back transfers).
  assign w_load = !r_dout_vld | dout_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch_data[gi]   = din[gi*DW +: DW];
      // sel values beyond the last channel never match any gi, so an
      // out-of-range select simply idles.
      assign w_man_hit[gi]   = din_vld[gi] & (sel == SELW'(gi));
      // Channels strictly after the last grant are searched first.
      assign w_above_ptr[gi] = (SELW'(gi) > r_ptr);
      assign w_ack_vec[gi]   = w_gnt & (w_gnt_idx == SELW'(gi));
    end
  endgenerate

  assign w_man_gnt = |w_man_hit;
  assign w_req_hi  = din_vld & w_above_ptr;

  // Round-robin pick: lowest requester above ptr, otherwise wrap and take
  // the lowest requester overall (which may be ptr itself).
  always_comb begin
    w_rr_gnt = |din_vld;
    w_rr_idx = '0;
    if (|w_req_hi) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (w_req_hi[i]) begin
          w_rr_idx = SELW'(i);
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (din_vld[i]) begin
          w_rr_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    if (mode) begin
      w_gnt     = w_rr_gnt;
      w_gnt_idx = w_rr_gnt ? w_rr_idx : '0;
    end else begin
      w_gnt     = w_man_gnt;
      w_gnt_idx = w_man_gnt ? sel : '0;
    end
  end

  // w_gnt_idx is forced to 0 without a grant, so it is always in range.
  assign w_gnt_data = w_ch_data[w_gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_ch  <= '0;
      r_dout_vld <= 1'b0;
      r_din_ack  <= '0;
      r_ptr      <= SELW'(N_CH - 1);
    end else begin
      r_din_ack <= '0;
      if (w_load) begin
        if (w_gnt) begin
          r_dout     <= w_gnt_data;
          r_dout_ch  <= w_gnt_idx;
          r_dout_vld <= 1'b1;
          r_din_ack  <= w_ack_vec;
          // Only round-robin grants advance the fairness pointer.
          if (mode) begin
            r_ptr <= w_gnt_idx;
          end
        end else if (dout_rdy) begin
          r_dout_vld <= 1'b0;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign dout_ch  = r_dout_ch;
  assign dout_vld = r_dout_vld;
  assign din_ack  = r_din_ack;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_nx1_rr
//   Directed bench for mux_nx1_rr (16 channels x 8 bits). A behavioural model
//   tracks the expected output register, channel, valid, ack and fairness
//   pointer; a negedge process compares the DUT against it every cycle.
//   Hand-computed literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_mux_nx1_rr;
  localparam int N    = 16;
  localparam int DW   = 8;
  localparam int SELW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      din_vld;
  logic [N-1:0]      din_ack;
  logic [DW-1:0]     dout;
  logic [SELW-1:0]   dout_ch;
  logic              dout_vld;
  logic              dout_rdy;

  int checks = 0;
  int errors = 0;

  mux_nx1_rr #(.N_CH(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .sel      (sel),
    .din      (din),
    .din_vld  (din_vld),
    .din_ack  (din_ack),
    .dout     (dout),
    .dout_ch  (dout_ch),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_started = 0;
  bit          m_vld;
  int          m_ch;
  int          m_dout;
  int          m_ptr;
  logic [N-1:0] m_ack;

  always @(posedge clk) begin
    int  g;
    bit  load;
    if (rst) begin
      m_started = 1;
      m_vld  = 0;
      m_ch   = 0;
      m_dout = 0;
      m_ack  = '0;
      m_ptr  = N - 1;
    end else if (m_started) begin
      m_ack = '0;
      load  = !m_vld || dout_rdy;
      g     = -1;
      if (!mode) begin
        if (int'(sel) < N && din_vld[sel]) g = int'(sel);
      end else begin
        for (int d = 1; d <= N && g < 0; d++)
          if (din_vld[(m_ptr + d) % N]) g = (m_ptr + d) % N;
      end
      if (load && g >= 0) begin
        m_vld    = 1;
        m_ch     = g;
        m_dout   = int'(din[g*DW +: DW]);
        m_ack[g] = 1'b1;
        if (mode) m_ptr = g;
      end else if (load && dout_rdy) begin
        m_vld = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      chk("model_vld",  64'(dout_vld), 64'(m_vld));
      chk("model_ch",   64'(dout_ch),  64'(m_ch));
      chk("model_dout", 64'(dout),     64'(m_dout));
      chk("model_ack",  64'(din_ack),  64'(m_ack));
      if (dout_vld && dout_rdy)
        $display("xfer t=%0t ch=%0d data=%02h ack=%04h", $time, dout_ch, dout, din_ack);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] exp_ack;
    int           alt [4];

    for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'hA0 | 8'(k);
    alt = '{1, 15, 1, 15};

    // 1 reset with all channels requesting
    rst = 1; mode = 1; sel = '0; din_vld = 16'hFFFF; dout_rdy = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_vld",  64'(dout_vld), 64'd0);
      chk("rst_ack",  64'(din_ack),  64'd0);
      chk("rst_dout", 64'(dout),     64'd0);
    end

    // 2 manual select of channel 5
    rst = 0; mode = 0; sel = 4'd5; din_vld = 16'h0020;
    tick();
    chk("man_dout", 64'(dout),     64'hA5);
    chk("man_ch",   64'(dout_ch),  64'd5);
    chk("man_vld",  64'(dout_vld), 64'd1);
    chk("man_ack",  64'(din_ack),  64'h0020);
    din_vld = '0;
    tick();
    chk("drain_vld", 64'(dout_vld), 64'd0);
    chk("drain_ack", 64'(din_ack),  64'd0);

    // 3 round-robin fairness, pointer still at 15 after manual grant
    mode = 1; din_vld = 16'hFFFF;
    for (int c = 0; c < 17; c++) begin
      tick();
      exp_ack = '0;
      exp_ack[c % N] = 1'b1;
      chk("rr_ch",  64'(dout_ch), 64'(c % N));
      chk("rr_ack", 64'(din_ack), 64'(exp_ack));
    end

    // 4 sparse requesters alternate without idle cycles (ptr=0 here)
    din_vld = 16'h8002;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("sparse_ch",  64'(dout_ch),  64'(alt[c]));
      chk("sparse_vld", 64'(dout_vld), 64'd1);
    end

    // 5 back-pressure freezes channel 15 sample
    dout_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_ch",   64'(dout_ch), 64'd15);
      chk("bp_dout", 64'(dout),    64'hAF);
      chk("bp_ack",  64'(din_ack), 64'd0);
    end
    dout_rdy = 1;
    tick();
    chk("bp_release_ch",  64'(dout_ch), 64'd1);
    chk("bp_release_ack", 64'(din_ack), 64'h0002);

    // 6 mid-operation reset while stalled (ptr=1 beforehand)
    dout_rdy = 0;
    tick();
    rst = 1;
    tick();
    chk("mrst_vld",  64'(dout_vld), 64'd0);
    chk("mrst_dout", 64'(dout),     64'd0);
    rst = 0; dout_rdy = 1; din_vld = 16'h0011;
    tick();
    chk("mrst_first_ch", 64'(dout_ch), 64'd0);
    tick();
    chk("mrst_second_ch", 64'(dout_ch), 64'd4);

    // mode switch: manual grant must not move ptr (ptr=4)
    mode = 0; sel = 4'd0; din_vld = 16'h0211;
    tick();
    chk("sw_man_ch", 64'(dout_ch), 64'd0);
    mode = 1;
    tick();
    chk("sw_rr_ch", 64'(dout_ch), 64'd9);

    // manual select of an idle channel drains the register
    mode = 0; sel = 4'd3;
    tick();
    chk("idle_sel_vld", 64'(dout_vld), 64'd0);
    chk("idle_sel_ack", 64'(din_ack),  64'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
